// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a length-prefixed stream of little-endian words from the UART,
// writes them into instruction memory and answers with an ACK or NAK byte.
module uart_program_loader #(
    parameter int         ADDR_WIDTH = 14,
    parameter int         BASE_ADDR  = 0,
    parameter logic [7:0] ACK_BYTE   = 8'hAA,
    parameter logic [7:0] NAK_BYTE   = 8'h55
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam logic [2:0] IDLE = 3'd0, LEN = 3'd1, DATA = 3'd2, WRITE = 3'd3, RESP = 3'd4;
    logic [2:0]            state;
    logic [1:0]            byte_idx;
    logic [31:0]           count, word_reg;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [31:0]           shifted_count, shifted_word;
    assign shifted_count = {rx_data, count[31:8]};
    assign shifted_word  = {rx_data, word_reg[31:8]};
    assign rx_ready = state == LEN || state == DATA;
    assign tx_valid = state == RESP;
    assign mem_we   = state == WRITE;
    assign busy     = state != IDLE;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            byte_idx  <= '0;
            count     <= '0;
            word_reg  <= '0;
            word_idx  <= '0;
            tx_data   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= LEN;
                    err      <= 1'b0;
                    byte_idx <= '0;
                    word_idx <= '0;
                end
                LEN: if (rx_valid) begin
                    count    <= shifted_count;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        if (shifted_count == '0) begin
                            state   <= RESP;
                            tx_data <= ACK_BYTE;
                        end else if ({1'b0, shifted_count} > (33'd1 << ADDR_WIDTH)) begin
                            state   <= RESP;
                            tx_data <= NAK_BYTE;
                            err     <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: if (rx_valid) begin
                    word_reg <= shifted_word;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state     <= WRITE;
                        mem_addr  <= ADDR_WIDTH'(BASE_ADDR) + word_idx[ADDR_WIDTH-1:0];
                        mem_wdata <= shifted_word;
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    state    <= (32'(word_idx) + 32'd1 == count) ? RESP : DATA;
                    tx_data  <= ACK_BYTE;
                end
                RESP: if (tx_ready) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: randomized loads against a queue-based model of the expected
// memory writes and response byte, including NAK, backpressure and mid-load reset.
module tb_uart_program_loader;
    localparam int AW = 4;
    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy, done, err;
    int            n_cmp = 0, n_bad = 0;
    logic [AW-1:0] got_a[$];
    logic [31:0]   got_d[$];

    uart_program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .ACK_BYTE(8'hAA), .NAK_BYTE(8'h55)) dut (
        .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("rx_tx_excl", 32'(rx_ready & tx_valid), 0);
        if (mem_we) begin
            got_a.push_back(mem_addr);
            got_d.push_back(mem_wdata);
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 0);
        check({tag, "_tx_valid"}, 32'(tx_valid), 0);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // called and returns at a negedge; the byte is accepted on the posedge in between
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 200 && !rx_ready; t++) @(negedge clk);
        check("rx_handshake", 32'(rx_ready), 1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_resp(input logic [7:0] exp_byte, input int hold, input logic exp_err);
        for (int t = 0; t < 200 && !tx_valid; t++) @(negedge clk);
        check("resp_valid", 32'(tx_valid), 1);
        check("resp_byte", 32'(tx_data), 32'(exp_byte));
        repeat (hold) begin
            @(negedge clk);
            check("bp_valid", 32'(tx_valid), 1);
            check("bp_byte", 32'(tx_data), 32'(exp_byte));
            check("bp_done", 32'(done), 0);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("done_pulse", 32'(done), 1);
        check("tx_valid_drop", 32'(tx_valid), 0);
        check("err_flag", 32'(err), 32'(exp_err));
        @(negedge clk);
        check("done_single", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    // model: count 0 -> ACK no writes; count > 2**AW -> NAK, err; else count writes at 0,1,...
    task automatic run_load(input logic [31:0] cnt, input logic [31:0] wq[$], input int gap,
                            input bit inject, input int hold);
        logic [31:0] words[$];
        logic [31:0] w;
        bit          nak;
        int          nwords;
        nak    = cnt > (32'd1 << AW);
        nwords = nak ? 0 : int'(cnt);
        got_a.delete();
        got_d.delete();
        pulse_start();
        check("start_busy", 32'(busy), 1);
        check("start_err_clear", 32'(err), 0);
        for (int k = 0; k < 4; k++) send_byte(cnt[8*k +: 8], gap);
        for (int i = 0; i < nwords; i++) begin
            w = (i < wq.size()) ? wq[i] : $urandom;
            words.push_back(w);
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], gap);
                if (inject && i == 0 && k == 1) pulse_start();
            end
            check("we_latency", 32'(mem_we), 1);
            check("we_addr", 32'(mem_addr), i % (1 << AW));
            check("we_data", mem_wdata, w);
            check("we_rx_ready", 32'(rx_ready), 0);
        end
        wait_resp(nak ? 8'h55 : 8'hAA, hold, nak);
        check("write_count", got_a.size(), nwords);
        for (int i = 0; i < nwords && i < got_a.size(); i++) begin
            check("mem_addr_seq", 32'(got_a[i]), i % (1 << AW));
            check("mem_data_seq", got_d[i], words[i]);
        end
    endtask

    initial begin
        logic [31:0] none[$];
        logic [31:0] dir[$];
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_zero("post_reset");
        dir = '{32'h12345678, 32'hDEADBEEF};
        run_load(2, dir, 0, 0, 0);
        run_load(0, none, 0, 0, 0);
        run_load(17, none, 0, 0, 0);
        run_load(16, none, 0, 0, 0);
        run_load(1, none, 0, 0, 20);
        dir = '{32'hCAFEF00D, 32'h0BADBEEF, 32'h01020304};
        run_load(3, dir, 0, 0, 0);
        run_load(3, dir, 6, 1, 0);
        run_load(32'h8000_0010, none, 0, 0, 0);
        for (int r = 0; r < 6; r++)
            run_load(32'($urandom_range(1, 16)), none, $urandom_range(0, 3), r[0], $urandom_range(0, 4));
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(8'(k == 0 ? 2 : 0), 0);
        for (int k = 0; k < 6; k++) send_byte(8'($urandom), 0);
        rstn = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clk);
        check_zero("mid_reset_hold");
        rstn = 1'b1;
        @(negedge clk);
        dir = '{32'hA5A55A5A};
        run_load(1, dir, 1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
